exec_memseq: RTL

EXEC_MEMSEQ -- requirements
Module: exec_memseq

---
 rtl/exec_memseq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/exec_memseq.sv
// Purpose : exec-stage memory sequencer; maps byte/word requests onto a 16-bit
//           lane-selected bus, splitting unaligned words into two bus cycles.
// Latency : accept N -> rsp_valid N+2 (single) / N+3 (split), +1 per wait state.
// Backpr. : req_ready only in IDLE; bus side waits on bus_ack, optional timeout.
// Ports   : clk/boot (sync active-high reset); req_* request handshake;
//           rsp_* one-cycle completion with held data/error; bus_* 16-bit bus.
module exec_memseq #(
   parameter int AW     = 20,
   parameter int TO_CYC = 255
) (
   input  logic          clk,
   input  logic          boot,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_we,
   input  logic          req_byte,
   input  logic [15:0]   req_wdata,
   output logic          rsp_valid,
   output logic [15:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          bus_cyc,
   output logic [AW-1:0] bus_addr,
   output logic          bus_we,
   output logic [1:0]    bus_sel,
   output logic [15:0]   bus_wdata,
   input  logic [15:0]   bus_rdata,
   input  logic          bus_ack
);

   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

   localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          split;
   logic          is_byte;
   logic [7:0]    lo_byte;   // FIRST-half read byte of a split word
   logic          timeout;
   logic [7:0]    byte_lane;

   // An ack in the cycle the counter hits the limit still wins.
   assign timeout   = (TO_CYC != 0) && (wait_cnt == CW'(TO_CYC)) && !bus_ack;
   assign req_ready = (state == IDLE) && !boot;
   assign byte_lane = bus_sel[1] ? bus_rdata[15:8] : bus_rdata[7:0];

   always_ff @(posedge clk) begin
      if (boot) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         split     <= 1'b0;
         is_byte   <= 1'b0;
         lo_byte   <= 8'h00;
         bus_cyc   <= 1'b0;
         bus_addr  <= '0;
         bus_we    <= 1'b0;
         bus_sel   <= 2'b00;
         bus_wdata <= 16'h0000;
         rsp_valid <= 1'b0;
         rsp_rdata <= 16'h0000;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state    <= FIRST;
                  bus_cyc  <= 1'b1;
                  bus_addr <= {req_addr[AW-1:1], 1'b0};
                  bus_we   <= req_we;
                  wait_cnt <= '0;
                  is_byte  <= req_byte;
                  split    <= !req_byte && req_addr[0];
                  if (req_byte) begin
                     bus_sel   <= req_addr[0] ? 2'b10 : 2'b01;
                     bus_wdata <= {req_wdata[7:0], req_wdata[7:0]};
                  end else if (req_addr[0]) begin
                     // Byte-swapped word serves both halves: low byte goes out
                     // on [15:8] first, high byte on [7:0] second.
                     bus_sel   <= 2'b10;
                     bus_wdata <= {req_wdata[7:0], req_wdata[15:8]};
                  end else begin
                     bus_sel   <= 2'b11;
                     bus_wdata <= req_wdata;
                  end
               end
            end
            FIRST: begin
               if (bus_ack) begin
                  if (split) begin
                     state    <= SECOND;
                     bus_addr <= bus_addr + AW'(2);  // wraps at 2^AW
                     bus_sel  <= 2'b01;
                     wait_cnt <= '0;
                     lo_byte  <= bus_rdata[15:8];
                  end else begin
                     state     <= IDLE;
                     bus_cyc   <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= bus_we ? 16'h0000 :
                                  (is_byte ? {8'h00, byte_lane} : bus_rdata);
                  end
               end else if (timeout) begin
                  state     <= IDLE;
                  bus_cyc   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 16'h0000;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            SECOND: begin
               if (bus_ack) begin
                  state     <= IDLE;
                  bus_cyc   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= bus_we ? 16'h0000 : {bus_rdata[7:0], lo_byte};
               end else if (timeout) begin
                  state     <= IDLE;
                  bus_cyc   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 16'h0000;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               bus_cyc <= 1'b0;
            end
         endcase
      end
   end

endmodule
